// File: rtl/drum_pkg.sv
//==============================================================================
// Module      : drum_pkg
// Description : Shared sequencer state encoding and default configuration.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package drum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int NUM_VOICES_D = 4;
    localparam int NUM_STEPS_D  = 16;
    localparam int TRIG_LEN_D   = 50_000;

endpackage

`default_nettype wire

// File: rtl/drum_step_sequencer_trig_pulse.sv
//==============================================================================
// Module      : trig_pulse
// Description : Retriggerable fixed-width pulse; fire reloads, clear aborts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trig_pulse
    import drum_pkg::*;
#(
    parameter int TRIG_LEN = TRIG_LEN_D
) (
    input  logic clock,
    input  logic reset,
    input  logic fire,
    input  logic clear,
    output logic pulse
);

    localparam int            CW     = $clog2(TRIG_LEN + 1);
    localparam logic [CW-1:0] C_LOAD = CW'(TRIG_LEN);

    logic [CW-1:0] r_count;

    // Clear beats fire so a stop in the same cycle as a step leaves nothing ringing.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (fire) begin
            r_count <= C_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign pulse = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/drum_step_sequencer.sv
//==============================================================================
// Module      : drum_step_sequencer
// Description : Pattern step sequencer with transport FSM and per-voice
//               trigger pulses. Optional accent plane under ACCENT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module drum_step_sequencer
    import drum_pkg::*;
#(
    parameter  int NUM_VOICES = NUM_VOICES_D,
    parameter  int NUM_STEPS  = NUM_STEPS_D,
    parameter  int TRIG_LEN   = TRIG_LEN_D,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int SW         = $clog2(NUM_STEPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  beat,
    output logic                  div_reset,
    input  logic                  pat_we,
    input  logic [VW-1:0]         pat_voice,
    input  logic [SW-1:0]         pat_step,
    input  logic                  pat_wdata,
`ifdef ACCENT_EN
    input  logic                  pat_accent,
    output logic [NUM_VOICES-1:0] accent,
`endif
    output logic [NUM_VOICES-1:0] trig,
    output logic [SW-1:0]         step,
    output logic                  bar_start,
    output logic                  running
);

    seq_state_t                            r_state;
    seq_state_t                            w_state_nxt;
    logic                                  r_beat_q;
    logic                                  w_edge;
    logic [SW-1:0]                         r_step;
    logic [SW-1:0]                         w_step_nxt;
    logic                                  w_advance;
    logic                                  w_clear;
    logic                                  r_bar_start;
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0]  r_pat;
    logic [NUM_VOICES-1:0]                 w_fire;
`ifdef ACCENT_EN
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0]  r_acc;
    logic [NUM_VOICES-1:0]                 w_fire_acc;
    logic [NUM_VOICES-1:0]                 w_clear_acc;
`endif

    assign w_edge  = beat ^ r_beat_q;
    assign w_clear = stop && (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_step_nxt  = r_step + SW'(1);
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                    w_advance   = 1'b1;
                    w_step_nxt  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    w_state_nxt = ARM;
                end else if (w_edge) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_beat_q    <= 1'b0;
            r_step      <= '0;
            r_bar_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_q    <= beat;
            r_bar_start <= w_advance && (w_step_nxt == '0);
            if (w_clear) begin
                r_step <= '0;
            end else if (w_advance) begin
                r_step <= w_step_nxt;
            end
        end
    end

    // Cells are read combinationally this cycle, so a same-cycle write lands after the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pat <= '0;
`ifdef ACCENT_EN
            r_acc <= '0;
`endif
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (pat_we && (pat_voice == VW'(v))) begin
                    r_pat[v][pat_step] <= pat_wdata;
`ifdef ACCENT_EN
                    r_acc[v][pat_step] <= pat_accent;
`endif
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign w_fire[v] = w_advance && r_pat[v][w_step_nxt];

        trig_pulse #(
            .TRIG_LEN (TRIG_LEN)
        ) u_trig (
            .clock (clock),
            .reset (reset),
            .fire  (w_fire[v]),
            .clear (w_clear),
            .pulse (trig[v])
        );

`ifdef ACCENT_EN
        // An unaccented re-fire must drop the accent so it tracks the latest hit only.
        assign w_fire_acc[v]  = w_fire[v] && r_acc[v][w_step_nxt];
        assign w_clear_acc[v] = w_clear || (w_fire[v] && !r_acc[v][w_step_nxt]);

        trig_pulse #(
            .TRIG_LEN (TRIG_LEN)
        ) u_accent (
            .clock (clock),
            .reset (reset),
            .fire  (w_fire_acc[v]),
            .clear (w_clear_acc[v]),
            .pulse (accent[v])
        );
`endif
    end

    assign step      = r_step;
    assign bar_start = r_bar_start;
    assign running   = (r_state != IDLE);
    assign div_reset = (r_state == ARM);

endmodule

`default_nettype wire
